// File: rtl/sram_nrmw_clr.sv
// sram_nrmw_clr: multi-port SRAM, async reads, sync writes, sweep clear.
// Optional macro SRAM_WR_BYPASS_EN: forward same-cycle writes to reads.
module sram_nrmw_clr #(
   parameter int                    SRAM_DEPTH    = 64,
   parameter int                    SRAM_INDEX    = 6,
   parameter int                    SRAM_WIDTH    = 32,
   parameter int                    NUM_RD        = 4,
   parameter int                    NUM_WR        = 4,
   parameter int                    CLR_PER_CYCLE = 4,
   parameter logic [SRAM_WIDTH-1:0] INIT_VALUE    = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clear_i,
   input  logic [NUM_RD*SRAM_INDEX-1:0] raddr_i,
   output logic [NUM_RD*SRAM_WIDTH-1:0] rdata_o,
   input  logic [NUM_WR-1:0]            we_i,
   input  logic [NUM_WR*SRAM_INDEX-1:0] waddr_i,
   input  logic [NUM_WR*SRAM_WIDTH-1:0] wdata_i,
   output logic                         ready_o,
   output logic                         wr_conflict_o
);

   typedef enum logic [1:0] {
      S_CLEAR = 2'd0,
      S_RUN   = 2'd1
   } state_t;

   localparam logic [SRAM_INDEX:0] LP_DEPTH =
      (SRAM_INDEX+1)'(SRAM_DEPTH);
   localparam logic [SRAM_INDEX-1:0] LP_LAST =
      SRAM_INDEX'(SRAM_DEPTH - CLR_PER_CYCLE);
   localparam logic [SRAM_INDEX-1:0] LP_STEP =
      SRAM_INDEX'(CLR_PER_CYCLE);

   function automatic logic f_in_range(
      input logic [SRAM_INDEX-1:0] a
   );
      return ({1'b0, a} < LP_DEPTH);
   endfunction

   logic [SRAM_WIDTH-1:0] r_mem [SRAM_DEPTH];

   state_t                r_state;
   state_t                w_state_nxt;
   logic [SRAM_INDEX-1:0] r_clr_ptr;
   logic [SRAM_INDEX-1:0] w_ptr_nxt;
   logic                  r_conflict;
   logic                  w_conflict;
   logic                  w_run;

   logic [SRAM_INDEX-1:0] w_wa [NUM_WR];
   logic [SRAM_WIDTH-1:0] w_wd [NUM_WR];
   logic                  w_wv [NUM_WR];

   assign w_run         = (r_state == S_RUN);
   assign ready_o       = w_run;
   assign wr_conflict_o = r_conflict;

   // A write is accepted only in RUN, in range, and without a clear.
   for (genvar gq = 0; gq < NUM_WR; gq++) begin : g_wr
      assign w_wa[gq] = waddr_i[gq*SRAM_INDEX +: SRAM_INDEX];
      assign w_wd[gq] = wdata_i[gq*SRAM_WIDTH +: SRAM_WIDTH];
      assign w_wv[gq] = we_i[gq] & w_run & ~clear_i &
                        f_in_range(w_wa[gq]);
   end

   // Flag any two accepted writes hitting the same entry.
   always_comb begin
      w_conflict = 1'b0;
      for (int p = 0; p < NUM_WR; p++) begin
         for (int q = p + 1; q < NUM_WR; q++) begin
            if (w_wv[p] && w_wv[q] && (w_wa[p] == w_wa[q]))
               w_conflict = 1'b1;
         end
      end
   end

   // Next-state and sweep pointer for the clear engine.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_clr_ptr;
      unique case (r_state)
         S_CLEAR: begin
            if (clear_i) begin
               w_ptr_nxt = '0;
            end else if (r_clr_ptr == LP_LAST) begin
               w_state_nxt = S_RUN;
               w_ptr_nxt   = '0;
            end else begin
               w_ptr_nxt = r_clr_ptr + LP_STEP;
            end
         end
         S_RUN: begin
            if (clear_i) begin
               w_state_nxt = S_CLEAR;
               w_ptr_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = S_CLEAR;
            w_ptr_nxt   = '0;
         end
      endcase
   end

   // Control state; reset restarts the sweep from entry 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_CLEAR;
         r_clr_ptr  <= '0;
         r_conflict <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_clr_ptr  <= w_ptr_nxt;
         r_conflict <= w_conflict;
      end
   end

   // Array update; later ports overwrite earlier ones on a collision.
   always_ff @(posedge clk) begin
      if (r_state == S_CLEAR) begin
         for (int c = 0; c < CLR_PER_CYCLE; c++)
            r_mem[r_clr_ptr + SRAM_INDEX'(c)] <= INIT_VALUE;
      end else begin
         for (int q = 0; q < NUM_WR; q++) begin
            if (w_wv[q])
               r_mem[w_wa[q]] <= w_wd[q];
         end
      end
   end

   for (genvar gp = 0; gp < NUM_RD; gp++) begin : g_rd
      logic [SRAM_INDEX-1:0] w_ra;
      logic [SRAM_WIDTH-1:0] w_rd;

      assign w_ra = raddr_i[gp*SRAM_INDEX +: SRAM_INDEX];
      assign rdata_o[gp*SRAM_WIDTH +: SRAM_WIDTH] = w_rd;

      // Read mux: INIT while clearing, zero when out of range.
      always_comb begin
         w_rd = '0;
         if (!w_run) begin
            w_rd = INIT_VALUE;
         end else if (f_in_range(w_ra)) begin
            w_rd = r_mem[w_ra];
`ifdef SRAM_WR_BYPASS_EN
            for (int q = 0; q < NUM_WR; q++) begin
               if (we_i[q] && f_in_range(w_wa[q]) &&
                   (w_wa[q] == w_ra))
                  w_rd = w_wd[q];
            end
`else
`endif
         end
      end
   end

endmodule

// File: tb/tb_sram_nrmw_clr.sv
// tb_sram_nrmw_clr: directed checks for sram_nrmw_clr.
// DEPTH=64, CLR_PER_CYCLE=4, INIT_VALUE=0xA5, 4R/4W.
module tb_sram_nrmw_clr;

   localparam int IW = 6;
   localparam int DW = 32;
   localparam logic [31:0] INIT = 32'h0000_00A5;

   logic          clk = 1'b0;
   logic          reset;
   logic          clear_i;
   logic [4*IW-1:0] raddr_i;
   logic [4*DW-1:0] rdata_o;
   logic [3:0]    we_i;
   logic [4*IW-1:0] waddr_i;
   logic [4*DW-1:0] wdata_i;
   logic          ready_o;
   logic          wr_conflict_o;

   int n_chk  = 0;
   int n_pass = 0;
   int n;

   sram_nrmw_clr #(
      .SRAM_DEPTH   (64),
      .SRAM_INDEX   (IW),
      .SRAM_WIDTH   (DW),
      .NUM_RD       (4),
      .NUM_WR       (4),
      .CLR_PER_CYCLE(4),
      .INIT_VALUE   (INIT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (clear_i),
      .raddr_i      (raddr_i),
      .rdata_o      (rdata_o),
      .we_i         (we_i),
      .waddr_i      (waddr_i),
      .wdata_i      (wdata_i),
      .ready_o      (ready_o),
      .wr_conflict_o(wr_conflict_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input int p, input logic [IW-1:0] a);
      raddr_i[p*IW +: IW] = a;
   endtask

   task automatic set_wr(input int p, input logic [IW-1:0] a,
                         input logic [DW-1:0] d);
      we_i[p]             = 1'b1;
      waddr_i[p*IW +: IW] = a;
      wdata_i[p*DW +: DW] = d;
   endtask

   function automatic logic [31:0] rd(input int p);
      return rdata_o[p*DW +: DW];
   endfunction

   task automatic rd_all(input string tag, input logic [IW-1:0] a,
                         input logic [31:0] exp);
      for (int p = 0; p < 4; p++) set_rd(p, a);
      #1;
      for (int p = 0; p < 4; p++) chk(tag, rd(p), exp);
   endtask

   task automatic wait_ready(output int cnt);
      cnt = 0;
      while (!ready_o && cnt < 40) begin
         tick();
         cnt++;
      end
   endtask

   initial begin
      logic [31:0] exp_same;
      reset   = 1'b0;
      clear_i = 1'b0;
      raddr_i = '0;
      we_i    = '0;
      waddr_i = '0;
      wdata_i = '0;

      // 1 + 5: reset, sweep length, writes dropped while clearing
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", {31'b0, ready_o}, 32'd0);
      chk("rst_conf", {31'b0, wr_conflict_o}, 32'd0);
      rd_all("clr_rd", 6'd5, INIT);
      reset = 1'b1;
      n = 0;
      while (!ready_o && n < 40) begin
         for (int p = 0; p < 4; p++)
            set_wr(p, IW'((4*n + p + 60) % 64),
                   32'hDEAD_0000 | 32'(n*4 + p));
         tick();
         n++;
      end
      we_i = '0;
      chk("sweep_len", 32'(n), 32'd16);
      for (int a = 0; a < 64; a += 4) begin
         for (int p = 0; p < 4; p++) set_rd(p, IW'(a + p));
         #1;
         for (int p = 0; p < 4; p++)
            chk("init_all", rd(p), INIT);
      end

      // 2: single write, same-cycle and next-cycle read
`ifdef SRAM_WR_BYPASS_EN
      exp_same = 32'h1234;
`else
      exp_same = INIT;
`endif
      set_wr(0, 6'd5, 32'h1234);
      rd_all("same_cyc", 6'd5, exp_same);
      tick();
      we_i = '0;
      rd_all("wr_rd", 6'd5, 32'h1234);
      chk("conf_single", {31'b0, wr_conflict_o}, 32'd0);

      // distinct addresses on all ports: no conflict
      for (int p = 0; p < 4; p++)
         set_wr(p, IW'(20 + p), 32'h100 + 32'(p));
      tick();
      we_i = '0;
      chk("conf_distinct", {31'b0, wr_conflict_o}, 32'd0);
      for (int p = 0; p < 4; p++) set_rd(p, IW'(20 + p));
      #1;
      for (int p = 0; p < 4; p++)
         chk("distinct_rd", rd(p), 32'h100 + 32'(p));

      // 3: ports 0,1,3 collide on addr 9
      set_wr(0, 6'd9, 32'h11);
      set_wr(1, 6'd9, 32'h22);
      set_wr(2, 6'd10, 32'h44);
      set_wr(3, 6'd9, 32'h33);
      tick();
      we_i = '0;
      chk("conf_set", {31'b0, wr_conflict_o}, 32'd1);
      set_rd(0, 6'd9);
      set_rd(1, 6'd10);
      set_rd(2, 6'd9);
      set_rd(3, 6'd10);
      #1;
      chk("hi_port_win", rd(0), 32'h33);
      chk("other_addr", rd(1), 32'h44);
      chk("hi_port_win2", rd(2), 32'h33);
      tick();
      chk("conf_clr", {31'b0, wr_conflict_o}, 32'd0);

      // 4: clear wins over write
      set_wr(0, 6'd2, 32'h77);
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      we_i    = '0;
      chk("clr_ready", {31'b0, ready_o}, 32'd0);
      rd_all("clr_rd2", 6'd5, INIT);
      wait_ready(n);
      chk("clr_len", 32'(n), 32'd16);
      rd_all("clr_a2", 6'd2, INIT);
      rd_all("clr_a5", 6'd5, INIT);
      rd_all("clr_a9", 6'd9, INIT);

      // async reset mid-run
      set_wr(0, 6'd0, 32'hBEEF);
      tick();
      we_i = '0;
      rd_all("pre_rst", 6'd0, 32'hBEEF);
      #2;
      reset = 1'b0;
      #1;
      chk("rst_async", {31'b0, ready_o}, 32'd0);
      tick();
      tick();
      reset = 1'b1;

      // 6: reset during sweep cycle 7, full sweep restarts
      repeat (7) tick();
      chk("mid_sweep", {31'b0, ready_o}, 32'd0);
      reset = 1'b0;
      #1;
      chk("mid_rst", {31'b0, ready_o}, 32'd0);
      tick();
      reset = 1'b1;
      wait_ready(n);
      chk("rst_sweep", 32'(n), 32'd16);
      rd_all("rst_a0", 6'd0, INIT);

      // clear_i during CLEAR restarts the sweep
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      repeat (5) tick();
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      wait_ready(n);
      chk("restart_len", 32'(n), 32'd16);
      rd_all("restart_rd", 6'd21, INIT);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
